// File: rtl/grover_search_multi.sv
// Multi-target Grover search engine: fixed-point amplitude vector, runtime iteration
// count and a sequential max-magnitude scan over all basis states.
module grover_search_multi #(
    parameter int NUM_BIT     = 4,
    parameter int FP_BIT      = 24,
    parameter int NUM_TARGETS = 2,
    parameter int ITER_W      = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [NUM_TARGETS*NUM_BIT-1:0]  target_idx,
    input  logic [NUM_TARGETS-1:0]          target_vld,
    input  logic [ITER_W-1:0]               num_iter,
    output logic signed [FP_BIT-1:0]        amp_out [1<<NUM_BIT],
    output logic [NUM_BIT-1:0]              result_idx,
    output logic signed [FP_BIT-1:0]        result_amp,
    output logic                            busy,
    output logic                            done
);
    localparam int N      = 1 << NUM_BIT;
    localparam int FRAC   = FP_BIT - 2;
    localparam int SUM_W  = FP_BIT + NUM_BIT;
    localparam int DIFF_W = FP_BIT + 2;
    localparam logic signed [FP_BIT-1:0] INIT_AMP =
        {{(FP_BIT-1){1'b0}}, 1'b1} << (FRAC - NUM_BIT/2);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_PHASE = 3'd2,
        ST_MEAN  = 3'd3,
        ST_SCAN  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t                           state_r, next_state_s;
    logic [NUM_TARGETS*NUM_BIT-1:0]   tgt_idx_r;
    logic [NUM_TARGETS-1:0]           tgt_vld_r;
    logic [ITER_W-1:0]                num_iter_r, iter_cnt_r;
    logic signed [FP_BIT-1:0]         amp_r [N];
    logic signed [FP_BIT-1:0]         refl_s [N];
    logic [N-1:0]                     mark_s;
    logic signed [SUM_W-1:0]          sum_s;
    logic signed [FP_BIT-1:0]         mean_s;
    logic signed [DIFF_W-1:0]         two_mean_s;
    logic [NUM_BIT-1:0]               scan_idx_r, best_idx_r, cand_idx_s;
    logic signed [FP_BIT-1:0]         best_amp_r, cand_amp_s, cur_amp_s;
    logic [FP_BIT-1:0]                best_mag_r, cand_mag_s, cur_mag_s;
    logic [NUM_BIT-1:0]               result_idx_r;
    logic signed [FP_BIT-1:0]         result_amp_r;
    logic                             busy_r, done_r;

    // Clamp a wide signed value into the signed FP_BIT range.
    function automatic logic signed [FP_BIT-1:0] sat(input logic signed [DIFF_W-1:0] v);
        if ((&v[DIFF_W-1:FP_BIT-1]) || !(|v[DIFF_W-1:FP_BIT-1])) begin
            return v[FP_BIT-1:0];
        end else if (v[DIFF_W-1]) begin
            return {1'b1, {(FP_BIT-1){1'b0}}};
        end else begin
            return {1'b0, {(FP_BIT-1){1'b1}}};
        end
    endfunction

    assign amp_out    = amp_r;
    assign result_idx = result_idx_r;
    assign result_amp = result_amp_r;
    assign busy       = busy_r;
    assign done       = done_r;

    // Mark mask: any valid slot holding index i marks it (duplicates collapse).
    always_comb begin
        mark_s = '0;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < NUM_TARGETS; k++) begin
                mark_s[i] = mark_s[i] |
                    (tgt_vld_r[k] & (tgt_idx_r[k*NUM_BIT +: NUM_BIT] == NUM_BIT'(i)));
            end
        end
    end

    // Inversion about the mean with floor division and saturation.
    always_comb begin
        sum_s = '0;
        for (int i = 0; i < N; i++) begin
            sum_s = sum_s + SUM_W'(amp_r[i]);
        end
        mean_s     = FP_BIT'(sum_s >>> NUM_BIT);
        two_mean_s = DIFF_W'(mean_s) <<< 1;
        for (int i = 0; i < N; i++) begin
            refl_s[i] = sat(two_mean_s - DIFF_W'(amp_r[i]));
        end
    end

    // Running-best candidate for the current scan position; ties keep the lower index.
    always_comb begin
        cur_amp_s = amp_r[scan_idx_r];
        cur_mag_s = cur_amp_s[FP_BIT-1] ? FP_BIT'(-cur_amp_s) : FP_BIT'(cur_amp_s);
        if ((scan_idx_r == '0) || (cur_mag_s > best_mag_r)) begin
            cand_idx_s = scan_idx_r;
            cand_amp_s = cur_amp_s;
            cand_mag_s = cur_mag_s;
        end else begin
            cand_idx_s = best_idx_r;
            cand_amp_s = best_amp_r;
            cand_mag_s = best_mag_r;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE:  next_state_s = start ? ST_INIT : ST_IDLE;
            ST_INIT:  next_state_s = (num_iter_r != '0) ? ST_PHASE : ST_SCAN;
            ST_PHASE: next_state_s = ST_MEAN;
            ST_MEAN:  next_state_s = ((iter_cnt_r + ITER_W'(1)) == num_iter_r) ? ST_SCAN : ST_PHASE;
            ST_SCAN:  next_state_s = (scan_idx_r == NUM_BIT'(N-1)) ? ST_DONE : ST_SCAN;
            ST_DONE:  next_state_s = start ? ST_INIT : ST_DONE;
            default:  next_state_s = ST_IDLE;
        endcase
    end

    // State register and registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s == ST_INIT) || (next_state_s == ST_PHASE) ||
                       (next_state_s == ST_MEAN) || (next_state_s == ST_SCAN);
            done_r  <= (next_state_s == ST_DONE);
        end
    end

    // Datapath: request capture, amplitude updates and the result scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt_idx_r    <= '0;
            tgt_vld_r    <= '0;
            num_iter_r   <= '0;
            iter_cnt_r   <= '0;
            scan_idx_r   <= '0;
            best_idx_r   <= '0;
            best_amp_r   <= '0;
            best_mag_r   <= '0;
            result_idx_r <= '0;
            result_amp_r <= '0;
            for (int i = 0; i < N; i++) amp_r[i] <= '0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        tgt_idx_r  <= target_idx;
                        tgt_vld_r  <= target_vld;
                        num_iter_r <= num_iter;
                        iter_cnt_r <= '0;
                    end
                end
                ST_INIT: begin
                    for (int i = 0; i < N; i++) amp_r[i] <= INIT_AMP;
                    iter_cnt_r <= '0;
                    scan_idx_r <= '0;
                end
                ST_PHASE: begin
                    for (int i = 0; i < N; i++) begin
                        amp_r[i] <= mark_s[i] ? sat(-DIFF_W'(amp_r[i])) : amp_r[i];
                    end
                end
                ST_MEAN: begin
                    for (int i = 0; i < N; i++) amp_r[i] <= refl_s[i];
                    iter_cnt_r <= iter_cnt_r + ITER_W'(1);
                    scan_idx_r <= '0;
                end
                ST_SCAN: begin
                    best_idx_r <= cand_idx_s;
                    best_amp_r <= cand_amp_s;
                    best_mag_r <= cand_mag_s;
                    scan_idx_r <= scan_idx_r + NUM_BIT'(1);
                    if (scan_idx_r == NUM_BIT'(N-1)) begin
                        result_idx_r <= cand_idx_s;
                        result_amp_r <= cand_amp_s;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_grover_search_multi.sv
// Randomised and directed bench for grover_search_multi against an integer-arithmetic
// model of the Grover iteration (phase flip, inversion about the floor mean, clamp).
module tb_grover_search_multi;
    localparam int NB = 4;
    localparam int FP = 24;
    localparam int NT = 2;
    localparam int IW = 8;
    localparam int N  = 1 << NB;
    localparam int TW = NT * NB;
    localparam longint INIT_V = 1048576;
    localparam longint MAX_V  = (64'sd1 <<< (FP-1)) - 1;
    localparam longint MIN_V  = -(64'sd1 <<< (FP-1));

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [TW-1:0]         target_idx;
    logic [NT-1:0]         target_vld;
    logic [IW-1:0]         num_iter;
    logic signed [FP-1:0]  amp_out [N];
    logic [NB-1:0]         result_idx;
    logic signed [FP-1:0]  result_amp;
    logic                  busy;
    logic                  done;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint exp_a [N];
    int     exp_idx;

    grover_search_multi #(.NUM_BIT(NB), .FP_BIT(FP), .NUM_TARGETS(NT), .ITER_W(IW)) dut (
        .clk(clk), .rst(rst), .start(start), .target_idx(target_idx),
        .target_vld(target_vld), .num_iter(num_iter), .amp_out(amp_out),
        .result_idx(result_idx), .result_amp(result_amp), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: state vector evolved with plain integer arithmetic.
    task automatic model(input logic [TW-1:0] tidx, input logic [NT-1:0] tvld, input int iters);
        bit     marked [N];
        longint sum, mean, v;
        for (int i = 0; i < N; i++) begin
            exp_a[i]  = INIT_V;
            marked[i] = 1'b0;
        end
        for (int k = 0; k < NT; k++)
            if (tvld[k]) marked[tidx[k*NB +: NB]] = 1'b1;
        for (int it = 0; it < iters; it++) begin
            for (int i = 0; i < N; i++) if (marked[i]) exp_a[i] = -exp_a[i];
            sum = 0;
            for (int i = 0; i < N; i++) sum += exp_a[i];
            mean = sum / N;
            if ((sum % N != 0) && (sum < 0)) mean -= 1;
            for (int i = 0; i < N; i++) begin
                v = 2 * mean - exp_a[i];
                exp_a[i] = (v > MAX_V) ? MAX_V : ((v < MIN_V) ? MIN_V : v);
            end
        end
        exp_idx = 0;
        for (int i = 1; i < N; i++) begin
            longint a, b;
            a = (exp_a[i] < 0) ? -exp_a[i] : exp_a[i];
            b = (exp_a[exp_idx] < 0) ? -exp_a[exp_idx] : exp_a[exp_idx];
            if (a > b) exp_idx = i;
        end
    endtask

    // One full search with input scrambling after acceptance and a start pulse while busy.
    task automatic run_search(input logic [TW-1:0] tidx, input logic [NT-1:0] tvld,
                              input int iters, input string tag);
        int edges;
        model(tidx, tvld, iters);
        @(negedge clk);
        target_idx = tidx; target_vld = tvld; num_iter = IW'(iters); start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        target_idx = TW'($urandom); target_vld = NT'($urandom); num_iter = IW'($urandom);
        @(posedge clk); #1;
        edges = 1;
        check({tag, "_init_amp"}, amp_out[N-1], INIT_V);
        check({tag, "_busy"}, busy, 1);
        @(negedge clk);
        start = 1'b0;
        while (done !== 1'b1 && edges < 1000) begin
            @(posedge clk); #1;
            edges++;
        end
        check({tag, "_latency"}, edges, 1 + 2*iters + N);
        check({tag, "_busy_low"}, busy, 0);
        for (int i = 0; i < N; i++) check($sformatf("%s_amp%0d", tag, i), amp_out[i], exp_a[i]);
        check({tag, "_res_idx"}, result_idx, exp_idx);
        check({tag, "_res_amp"}, result_amp, exp_a[exp_idx]);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; target_idx = '0; target_vld = '0; num_iter = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_amp", amp_out[3], 0);
        check("rst_idx", result_idx, 0);
        @(negedge clk);
        rst = 1'b0;

        run_search(8'h05, 2'b01, 1, "t5_i1");
        check("t5_i1_amp5_abs", amp_out[5], 2883584);
        check("t5_i1_amp0_abs", amp_out[0], 786432);
        check("t5_i1_idx_abs", result_idx, 5);

        run_search(8'h05, 2'b01, 3, "t5_i3");
        check("t5_i3_high", (amp_out[5] > 3984588) ? 1 : 0, 1);
        check("t5_i3_idx_abs", result_idx, 5);

        run_search(8'h3A, 2'b11, 0, "i0");
        check("i0_idx_abs", result_idx, 0);

        run_search(8'h99, 2'b11, 1, "dup9");
        check("dup9_amp9_abs", amp_out[9], 2883584);

        run_search(8'h0C, 2'b01, 1, "restart12");
        check("restart12_idx_abs", result_idx, 12);
        check("restart12_amp_abs", amp_out[12], 2883584);

        for (int r = 0; r < 5; r++)
            run_search(TW'($urandom), NT'($urandom), $urandom_range(0, 6), $sformatf("rnd%0d", r));

        // Reset in the middle of a MEAN step, after a start pulse issued while busy.
        @(negedge clk);
        target_idx = 8'h05; target_vld = 2'b01; num_iter = 8'd3; start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_amp5", amp_out[5], 0);
        check("mrst_amp0", amp_out[0], 0);
        check("mrst_idx", result_idx, 0);
        check("mrst_res_amp", result_amp, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("mrst_idle_busy", busy, 0);
        check("mrst_idle_done", done, 0);
        check("mrst_idle_amp", amp_out[7], 0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule
